// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching fetch stage.
package fetch_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch ring buffer of {pc, instr} entries; flush empties it in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Decoupled fetch: credit-limited request issue, in-order responses, prefetch queue.
// Optional misaligned-target trap enabled with `define FETCH_MISALIGN_CHK_EN.
module fetch_prefetch_unit #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              QDEPTH   = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable_pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] alu_out,
    input  logic            excep_taken,
    input  logic [XLEN-1:0] csr_excep,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc_out
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            fetch_misalign
`endif
);

    import fetch_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   out_nxt;
    logic [OW-1:0]   drop;
    logic [SW-1:0]   credit_used;
    logic [CW-1:0]   q_count;
    logic            redirect;
    logic            req_hs;
    logic            rsp_ok;
    logic            q_push;
    logic            q_pop;
    logic            q_full;
    logic            q_empty;
    logic            trap;
    fetch_entry_t    q_in;
    fetch_entry_t    q_head;

    assign redirect = excep_taken | branch_taken;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned;

    assign target     = excep_taken ? csr_excep : alu_out;
    assign misaligned = |target[1:0];

    // Trap holds until a redirect to an aligned target arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        trap <= 1'b0;
        else if (redirect) trap <= misaligned;
    end

    assign fetch_misalign = trap;
`else
    assign target = (excep_taken ? csr_excep : alu_out) & ~XLEN'(3);
    assign trap   = 1'b0;
`endif

    // Queue slots are reserved for every in-flight request, so a response never finds it full.
    assign credit_used = SW'(q_count) + SW'(outstanding);
    assign req_hs      = req_valid && req_ready;
    assign rsp_ok      = rsp_valid && (outstanding != '0);
    assign out_nxt     = outstanding + OW'(req_hs) - OW'(rsp_ok);

    assign q_push = rsp_ok && (drop == '0) && !redirect && !trap;
    assign q_pop  = instr_valid && instr_ready;
    assign q_in   = '{pc: resp_pc, instr: rsp_data};

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .flush     (redirect),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        case (state)
            IDLE: if (enable_pc) state_nxt = RUN;
            RUN: begin
                if (!enable_pc) state_nxt = IDLE;
                req_valid = (credit_used < SW'(QDEPTH)) && (outstanding < OW'(MAX_OUT)) && !trap;
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect && enable_pc) state_nxt = RUN;
    end

    // On redirect every request still in flight (including one accepted now) is stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= out_nxt;
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                drop     <= out_nxt;
            end else begin
                if (req_hs)                     fetch_pc <= fetch_pc + XLEN'(PC_INC);
                if (q_push)                     resp_pc  <= resp_pc + XLEN'(PC_INC);
                if (rsp_ok && (drop != '0))     drop     <= drop - 1'b1;
            end
        end
    end

    assign req_addr    = fetch_pc;
    assign instr_valid = !q_empty;
    assign instruction = q_head.instr;
    assign pc_out      = q_head.pc;

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!reset) !(q_push && q_full && !q_pop)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized scoreboard bench for fetch_prefetch_unit with an in-order memory model.
`timescale 1ns/1ps
module tb_fetch_prefetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable_pc = 1'b0;
    logic        branch_taken = 1'b0;
    logic        excep_taken = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] csr_excep = '0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        instr_ready = 1'b0;
    logic        req_valid;
    logic        instr_valid;
    logic [31:0] req_addr;
    logic [31:0] instruction;
    logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    fetch_prefetch_unit #(
        .XLEN(32), .QDEPTH(4), .MAX_OUT(2), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset), .enable_pc(enable_pc),
        .branch_taken(branch_taken), .alu_out(alu_out),
        .excep_taken(excep_taken), .csr_excep(csr_excep),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .pc_out(pc_out)
`ifdef FETCH_MISALIGN_CHK_EN
        , .fetch_misalign(fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9E17;
    endfunction

    // Memory model: in-order responses, random latency >= 1 cycle.
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          last_due = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          mem_flush = 1'b1;

    initial forever begin
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        if (mem_flush) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (pend_due.size() > 0 && cyc >= pend_due[0]) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    end

    // Reference: live requests (issued after the latest redirect) must come out in order.
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];
    logic [31:0] exp_req_pc = RST_PC;
    logic [31:0] post_redir_pc;
    bit          post_redir_wait = 1'b0;
    bit          trap_m = 1'b0;
    bit          prev_en = 1'b0;
    int          hs_cnt = 0;
    int          first_hs = -1;
    int          first_iv = -1;

    initial forever begin
        logic [31:0] tgt;
        int          due;
        @(negedge clk);
        if (!reset) begin
            exp_pc_q.delete();
            exp_ins_q.delete();
            exp_req_pc = RST_PC;
            trap_m = 1'b0;
            prev_en = 1'b0;
            hs_cnt = 0;
            first_hs = -1;
            first_iv = -1;
            last_due = 0;
            continue;
        end
        if (req_valid) chk("issue_needs_prior_enable", {31'b0, prev_en}, 32'd1);
        if (instr_valid && first_iv < 0) first_iv = cyc;
        if (instr_valid && instr_ready) begin
            if (exp_pc_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_instr: got pc %h, expected no entry (cycle %0d)", pc_out, cyc);
            end else begin
                chk("pop_pc", pc_out, exp_pc_q.pop_front());
                chk("pop_instr", instruction, exp_ins_q.pop_front());
            end
            if (post_redir_wait) begin
                post_redir_pc = pc_out;
                post_redir_wait = 1'b0;
            end
        end
        if (req_valid && req_ready) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
`ifdef FETCH_MISALIGN_CHK_EN
            chk("issue_in_trap", {31'b0, trap_m}, 32'd0);
`endif
            chk("req_addr", req_addr, exp_req_pc);
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(req_addr);
            pend_due.push_back(due);
            if (!(branch_taken || excep_taken)) begin
                exp_pc_q.push_back(exp_req_pc);
                exp_ins_q.push_back(mem_word(exp_req_pc));
            end
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (branch_taken || excep_taken) begin
            tgt = excep_taken ? csr_excep : alu_out;
`ifdef FETCH_MISALIGN_CHK_EN
            trap_m = (tgt[1:0] != 2'b00);
`else
            tgt[1:0] = 2'b00;
`endif
            exp_req_pc = tgt;
            exp_pc_q.delete();
            exp_ins_q.delete();
            post_redir_pc = 'x;
            post_redir_wait = 1'b1;
        end
        prev_en = enable_pc;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input bit en, input bit rr, input bit ir);
        enable_pc    = en;
        req_ready    = rr;
        instr_ready  = ir;
        branch_taken = 1'b0;
        excep_taken  = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req_addr", req_addr, RST_PC);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] tg;
        int          sel;
        repeat (3) tick();
        chk_reset_state();

        // Release with decode stalled: four credits fill, head holds at 0x0.
        drv(1, 1, 0);
        reset = 1'b1;
        mem_flush = 1'b0;
        repeat (12) tick();
        chk("stall_hs_count", 32'(hs_cnt), 32'd4);
        chk("first_latency", 32'(first_iv - first_hs), 32'd2);
        chk("stall_req_valid", {31'b0, req_valid}, 32'd0);
        chk("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("stall_head_pc", pc_out, 32'h0);
        drv(1, 1, 1);
        repeat (20) tick();

        // Branch with two requests in flight.
        lat_lo = 3;
        lat_hi = 3;
        repeat (8) tick();
        drv(1, 1, 1);
        branch_taken = 1'b1;
        alu_out = 32'h100;
        tick();
        drv(1, 1, 1);
        repeat (15) tick();
        chk("branch_first_pc", post_redir_pc, 32'h100);

        // Exception wins over a simultaneous branch.
        branch_taken = 1'b1;
        alu_out = 32'h200;
        excep_taken = 1'b1;
        csr_excep = 32'h80;
        tick();
        chk("excep_prio_req_addr", req_addr, 32'h80);
        drv(1, 1, 1);
        repeat (12) tick();
        chk("excep_first_pc", post_redir_pc, 32'h80);

        // Redirect while memory refuses requests.
        lat_lo = 1;
        lat_hi = 2;
        drv(1, 0, 1);
        repeat (4) tick();
        branch_taken = 1'b1;
        alu_out = 32'h40;
        tick();
        chk("stall_redirect_req_addr", req_addr, 32'h40);
        drv(1, 1, 1);
        repeat (12) tick();
        chk("stall_redirect_first_pc", post_redir_pc, 32'h40);

        // Address wrap at the top of the space.
        branch_taken = 1'b1;
        alu_out = 32'hFFFF_FFF8;
        tick();
        drv(1, 1, 1);
        repeat (15) tick();
        chk("wrap_first_pc", post_redir_pc, 32'hFFFF_FFF8);

`ifdef FETCH_MISALIGN_CHK_EN
        branch_taken = 1'b1;
        alu_out = 32'h102;
        tick();
        chk("misalign_flag_set", {31'b0, fetch_misalign}, 32'd1);
        chk("misalign_no_issue", {31'b0, req_valid}, 32'd0);
        drv(1, 1, 1);
        repeat (6) tick();
        chk("misalign_still_quiet", {31'b0, req_valid}, 32'd0);
        branch_taken = 1'b1;
        alu_out = 32'h200;
        tick();
        chk("misalign_flag_clear", {31'b0, fetch_misalign}, 32'd0);
        drv(1, 1, 1);
        repeat (12) tick();
        chk("misalign_resume_pc", post_redir_pc, 32'h200);
`else
        branch_taken = 1'b1;
        alu_out = 32'h103;
        tick();
        chk("unaligned_forced_req_addr", req_addr, 32'h100);
        drv(1, 1, 1);
        repeat (12) tick();
        chk("unaligned_forced_pc", post_redir_pc, 32'h100);
`endif

        // Random traffic with a reset in the middle.
        lat_lo = 1;
        lat_hi = 4;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) begin
                drv(0, 0, 0);
                reset = 1'b0;
                mem_flush = 1'b1;
                repeat (3) tick();
                chk_reset_state();
                reset = 1'b1;
                mem_flush = 1'b0;
            end
            drv($urandom_range(9, 0) != 0, $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7);
            if ($urandom_range(19, 0) == 0) begin
                tg = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF0 : $urandom();
`ifdef FETCH_MISALIGN_CHK_EN
                if ($urandom_range(5, 0) != 0) tg[1:0] = 2'b00;
`endif
                sel = $urandom_range(2, 0);
                if (sel != 1) begin
                    branch_taken = 1'b1;
                    alu_out = tg;
                end
                if (sel != 0) begin
                    excep_taken = 1'b1;
                    csr_excep = tg;
                    if (sel == 2) alu_out = tg ^ 32'h0000_1000;
                end
            end
        end

        // Drain: stop fetching and let every live entry reach decode.
        tick();
        drv(0, 1, 1);
        repeat (40) tick();
        chk("drain_expected_left", 32'(exp_pc_q.size()), 32'd0);
        chk("drain_mem_pending", 32'(pend_addr.size()), 32'd0);
        chk("drain_instr_valid", {31'b0, instr_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
